// File: rtl/scs8hd_scan_pkg.sv
// Shared types and helpers for the scan-chain driver.
// Holds the sequencer state encoding and the bit-counter width function.
package scs8hd_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CAPT   = 2'd2,
    UNLOAD = 2'd3
  } scan_state_e;

  // Bit counter must reach CHAIN_LEN-1 without wrapping.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len) + 1;
  endfunction

endpackage

// File: rtl/scs8hd_scan_shreg.sv
// Parallel-load, serial-shift register of WIDTH bits.
// Shifts towards the MSB, taking sin into the LSB; load has priority over shift.
module scs8hd_scan_shreg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  // Register update: async clear, then parallel load or one-bit shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

// File: rtl/scs8hd_scan_drv.sv
// Scan-chain driver: loads a pattern into a scan chain, applies one capture
// cycle, then unloads the chain response into RESP and pulses DONE.
// Optional response compare (EXP_IN input, FAIL output) is enabled by
// defining SCS8HD_SCAN_DRV_CMP_EN.
//
// Handshake: START is sampled only while idle (BUSY=0, including the DONE
// cycle); a START seen while BUSY=1 is dropped, never queued. DONE is a
// single-cycle strobe marking RESP (and FAIL) valid; they hold until the
// next DONE.
//
// SCD is taken straight from the pattern register MSB. That register shifts
// in zeros, so it is empty once the last pattern bit has gone out, which
// keeps SCD low in CAPT, UNLOAD and IDLE without extra muxing.
module scs8hd_scan_drv
  import scs8hd_scan_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SO,
`ifdef SCS8HD_SCAN_DRV_CMP_EN
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  output logic                 FAIL,
`endif
  output logic                 SCE,
  output logic                 SCD,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic [1:0]           dbg_state
);

  localparam int            CW       = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

  scan_state_e          state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic                 sce_d, busy_d, done_d;
  logic                 pat_ld, pat_sh, rsp_ld, rsp_sh, resp_upd;
  logic [CHAIN_LEN-1:0] pat_q, rsp_q, rsp_next;

  scs8hd_scan_shreg #(.WIDTH(CHAIN_LEN)) u_pat (
    .clk   (CLK),
    .rst   (RESET),
    .load  (pat_ld),
    .shift (pat_sh),
    .sin   (1'b0),
    .din   (PAT_IN),
    .q     (pat_q)
  );

  scs8hd_scan_shreg #(.WIDTH(CHAIN_LEN)) u_rsp (
    .clk   (CLK),
    .rst   (RESET),
    .load  (rsp_ld),
    .shift (rsp_sh),
    .sin   (SO),
    .din   ({CHAIN_LEN{1'b0}}),
    .q     (rsp_q)
  );

  // Pattern MSB goes out first; response is the shift register with the
  // current SO appended and the oldest bit dropped.
  assign SCD       = 1'(pat_q >> (CHAIN_LEN - 1));
  assign rsp_next  = CHAIN_LEN'({rsp_q, SO});
  assign dbg_state = state;

  // Next-state and next-output decode for the load/capture/unload sequence.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sce_d    = SCE;
    busy_d   = BUSY;
    done_d   = 1'b0;
    pat_ld   = 1'b0;
    pat_sh   = 1'b0;
    rsp_ld   = 1'b0;
    rsp_sh   = 1'b0;
    resp_upd = 1'b0;
    case (state)
      IDLE: begin
        sce_d  = 1'b0;
        busy_d = 1'b0;
        if (START) begin
          state_d = LOAD;
          cnt_d   = '0;
          sce_d   = 1'b1;
          busy_d  = 1'b1;
          pat_ld  = 1'b1;
          rsp_ld  = 1'b1;
        end
      end
      LOAD: begin
        pat_sh = 1'b1;
        if (cnt == CNT_LAST) begin
          state_d = CAPT;
          cnt_d   = '0;
          sce_d   = 1'b0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      CAPT: begin
        state_d = UNLOAD;
        cnt_d   = '0;
        sce_d   = 1'b1;
      end
      UNLOAD: begin
        rsp_sh = 1'b1;
        if (cnt == CNT_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          sce_d    = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          resp_upd = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sce_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any sequence.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      SCE   <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      RESP  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      SCE   <= sce_d;
      BUSY  <= busy_d;
      DONE  <= done_d;
      if (resp_upd) RESP <= rsp_next;
    end
  end

`ifdef SCS8HD_SCAN_DRV_CMP_EN
  logic [CHAIN_LEN-1:0] exp_q;

  // Expected response is latched with the pattern; FAIL updates with RESP.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      exp_q <= '0;
      FAIL  <= 1'b0;
    end else begin
      if (pat_ld)   exp_q <= EXP_IN;
      if (resp_upd) FAIL  <= (rsp_next != exp_q);
    end
  end
`endif

endmodule

// File: tb/tb_scs8hd_scan_drv.sv
// Bench for scs8hd_scan_drv with an 8-flop chain whose capture D = ~Q.
// Expected behaviour comes from a cycle timeline of the sequence
// (load 1..N, capture N+1, unload N+2..2N+1, DONE at 2N+2) and RESP = ~pattern.
module tb_scs8hd_scan_drv;

  localparam int N      = 8;
  localparam int DONE_C = 2 * N + 2;

  logic         CLK = 1'b0;
  logic         RESET, START, SO;
  logic [N-1:0] PAT_IN, RESP;
  logic         SCE, SCD, BUSY, DONE;
  logic [1:0]   dbg_state;
`ifdef SCS8HD_SCAN_DRV_CMP_EN
  logic [N-1:0] EXP_IN;
  logic         FAIL;
  logic         fail_log [0:63];
`endif

  int total = 0;
  int bad   = 0;

  logic         sce_log  [0:63];
  logic         scd_log  [0:63];
  logic         busy_log [0:63];
  logic         done_log [0:63];
  logic [N-1:0] resp_log [0:63];

  // ---------------- clock / chain model ----------------
  always #5 CLK = ~CLK;

  logic [N-1:0] chain = '0;
  assign SO = chain[N-1];
  always @(posedge CLK) chain <= SCE ? {chain[N-2:0], SCD} : ~chain;

  scs8hd_scan_drv #(.CHAIN_LEN(N)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .PAT_IN    (PAT_IN),
    .SO        (SO),
`ifdef SCS8HD_SCAN_DRV_CMP_EN
    .EXP_IN    (EXP_IN),
    .FAIL      (FAIL),
`endif
    .SCE       (SCE),
    .SCD       (SCD),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESP      (RESP),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // {SCE, SCD, BUSY, DONE} expected in cycle c after START accepted in cycle 0.
  function automatic logic [3:0] exp_sig(input logic [N-1:0] p, input int c);
    logic sce, scd, busy, done;
    sce  = (c >= 1 && c <= N) || (c >= N + 2 && c <= 2 * N + 1);
    scd  = (c >= 1 && c <= N) ? p[N - c] : 1'b0;
    busy = (c >= 1 && c <= 2 * N + 1);
    done = (c == DONE_C);
    return {sce, scd, busy, done};
  endfunction

  // ---------------- driver ----------------
  // Raises START with pat in cycle 0, then logs outputs for cycles 1..ncyc.
  // START stays high while c < hold, and is also high in cycle pulse_at.
  // PAT_IN switches to pat2 from cycle 1 on.
  task automatic run_seq(input logic [N-1:0] pat, input logic [N-1:0] pat2,
                         input int hold, input int pulse_at, input int ncyc);
    PAT_IN = pat;
    START  = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge CLK); #1;
      sce_log[c]  = SCE;
      scd_log[c]  = SCD;
      busy_log[c] = BUSY;
      done_log[c] = DONE;
      resp_log[c] = RESP;
`ifdef SCS8HD_SCAN_DRV_CMP_EN
      fail_log[c] = FAIL;
`endif
      START  = (c < hold) || (c == pulse_at);
      PAT_IN = pat2;
    end
    START = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b1; START = 1'b0; PAT_IN = '0;
`ifdef SCS8HD_SCAN_DRV_CMP_EN
    EXP_IN = '0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    total++; if (SCE !== 1'b0)  begin bad++; $display("FAIL reset_sce got=%b want=0", SCE); end
    total++; if (SCD !== 1'b0)  begin bad++; $display("FAIL reset_scd got=%b want=0", SCD); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", DONE); end
    total++; if (RESP !== '0)   begin bad++; $display("FAIL reset_resp got=%h want=00", RESP); end
`ifdef SCS8HD_SCAN_DRV_CMP_EN
    total++; if (FAIL !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b want=0", FAIL); end
`endif
    RESET = 1'b0;
    @(posedge CLK); #1;
    total++;
    if ({SCE, BUSY, DONE} !== 3'b000) begin
      bad++; $display("FAIL idle_after_reset got=%b want=000", {SCE, BUSY, DONE});
    end
  endtask

  task automatic test_a5();
    logic [N-1:0] p;
    p = 8'hA5;
    run_seq(p, 8'h00, 1, -1, DONE_C + 2);
    for (int c = 1; c <= DONE_C + 2; c++) begin
      total++;
      if ({sce_log[c], scd_log[c], busy_log[c], done_log[c]} !== exp_sig(p, c)) begin
        bad++;
        $display("FAIL a5_timeline c=%0d got=%b want=%b", c,
                 {sce_log[c], scd_log[c], busy_log[c], done_log[c]}, exp_sig(p, c));
      end
    end
    total++; if (resp_log[DONE_C] !== 8'h5A)
      begin bad++; $display("FAIL a5_resp got=%h want=5a", resp_log[DONE_C]); end
    total++; if (resp_log[DONE_C + 2] !== 8'h5A)
      begin bad++; $display("FAIL a5_resp_hold got=%h want=5a", resp_log[DONE_C + 2]); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] p;
    p = 8'($urandom_range(1, 255));
    run_seq(p, p, 1, -1, 12);
    #2 RESET = 1'b1;
    #1;
    total++; if ({SCE, SCD, BUSY, DONE} !== 4'b0000)
      begin bad++; $display("FAIL rst_mid_ctrl got=%b want=0000", {SCE, SCD, BUSY, DONE}); end
    total++; if (RESP !== '0)
      begin bad++; $display("FAIL rst_mid_resp got=%h want=00", RESP); end
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      total++;
      if ({SCE, BUSY, DONE} !== 3'b000) begin
        bad++; $display("FAIL rst_mid_hold k=%0d got=%b want=000", k, {SCE, BUSY, DONE});
      end
    end
    RESET = 1'b0;
    p = 8'($urandom_range(0, 255));
    run_seq(p, 8'($urandom_range(0, 255)), 1, -1, DONE_C);
    for (int c = 1; c <= DONE_C; c++) begin
      total++;
      if ({sce_log[c], scd_log[c], busy_log[c], done_log[c]} !== exp_sig(p, c)) begin
        bad++;
        $display("FAIL rst_fresh_timeline c=%0d got=%b want=%b", c,
                 {sce_log[c], scd_log[c], busy_log[c], done_log[c]}, exp_sig(p, c));
      end
    end
    total++; if (resp_log[DONE_C] !== ~p)
      begin bad++; $display("FAIL rst_fresh_resp got=%h want=%h", resp_log[DONE_C], ~p); end
  endtask

  task automatic test_start_ignored();
    logic [N-1:0] p1, p2;
    int nd;
    p1 = 8'($urandom_range(0, 255));
    p2 = p1 ^ 8'($urandom_range(1, 255));
    run_seq(p1, p2, 1, 5, DONE_C + 7);
    nd = 0;
    for (int c = 1; c <= DONE_C + 7; c++) begin
      nd += int'(done_log[c]);
      total++;
      if ({sce_log[c], scd_log[c], busy_log[c], done_log[c]} !== exp_sig(p1, c)) begin
        bad++;
        $display("FAIL ignore_timeline c=%0d got=%b want=%b", c,
                 {sce_log[c], scd_log[c], busy_log[c], done_log[c]}, exp_sig(p1, c));
      end
    end
    total++; if (nd !== 1)
      begin bad++; $display("FAIL ignore_done_count got=%0d want=1", nd); end
    total++; if (resp_log[DONE_C] !== ~p1)
      begin bad++; $display("FAIL ignore_resp got=%h want=%h", resp_log[DONE_C], ~p1); end
  endtask

  task automatic test_back_to_back(input logic [N-1:0] p1, input logic [N-1:0] p2);
    logic [3:0] want;
    run_seq(p1, p2, DONE_C + 1, -1, 2 * DONE_C + 1);
    for (int c = 1; c <= 2 * DONE_C + 1; c++) begin
      want = (c <= DONE_C) ? exp_sig(p1, c) : exp_sig(p2, c - DONE_C);
      total++;
      if ({sce_log[c], scd_log[c], busy_log[c], done_log[c]} !== want) begin
        bad++;
        $display("FAIL b2b_timeline p1=%h c=%0d got=%b want=%b", p1, c,
                 {sce_log[c], scd_log[c], busy_log[c], done_log[c]}, want);
      end
    end
    total++; if (resp_log[DONE_C] !== ~p1)
      begin bad++; $display("FAIL b2b_resp1 got=%h want=%h", resp_log[DONE_C], ~p1); end
    total++; if (resp_log[DONE_C + 10] !== ~p1)
      begin bad++; $display("FAIL b2b_resp1_hold got=%h want=%h", resp_log[DONE_C + 10], ~p1); end
    total++; if (resp_log[2 * DONE_C] !== ~p2)
      begin bad++; $display("FAIL b2b_resp2 got=%h want=%h", resp_log[2 * DONE_C], ~p2); end
  endtask

  task automatic test_random();
    logic [N-1:0] p;
    for (int i = 0; i < 4; i++) begin
      p = 8'($urandom_range(0, 255));
      run_seq(p, 8'($urandom_range(0, 255)), 1, -1, DONE_C);
      for (int c = 1; c <= DONE_C; c++) begin
        total++;
        if ({sce_log[c], scd_log[c], busy_log[c], done_log[c]} !== exp_sig(p, c)) begin
          bad++;
          $display("FAIL rand_timeline p=%h c=%0d got=%b want=%b", p, c,
                   {sce_log[c], scd_log[c], busy_log[c], done_log[c]}, exp_sig(p, c));
        end
      end
      total++; if (resp_log[DONE_C] !== ~p)
        begin bad++; $display("FAIL rand_resp p=%h got=%h want=%h", p, resp_log[DONE_C], ~p); end
    end
  endtask

`ifdef SCS8HD_SCAN_DRV_CMP_EN
  task automatic test_compare();
    EXP_IN = 8'h5A;
    run_seq(8'hA5, 8'h00, 1, -1, DONE_C);
    total++; if (fail_log[DONE_C] !== 1'b0)
      begin bad++; $display("FAIL cmp_match got=%b want=0", fail_log[DONE_C]); end
    EXP_IN = 8'h5B;
    run_seq(8'hA5, 8'h00, 1, -1, DONE_C + 2);
    total++; if (fail_log[DONE_C - 1] !== 1'b0)
      begin bad++; $display("FAIL cmp_hold_prev got=%b want=0", fail_log[DONE_C - 1]); end
    total++; if (fail_log[DONE_C] !== 1'b1)
      begin bad++; $display("FAIL cmp_mismatch got=%b want=1", fail_log[DONE_C]); end
    total++; if (fail_log[DONE_C + 2] !== 1'b1)
      begin bad++; $display("FAIL cmp_mismatch_hold got=%b want=1", fail_log[DONE_C + 2]); end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_a5();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back(8'h00, 8'hFF);
    test_back_to_back(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    test_random();
`ifdef SCS8HD_SCAN_DRV_CMP_EN
    test_compare();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
